// File: rtl/baccarat_statemachine_pkg.sv
// Shared types and constants for the baccarat dealing controller.
// The state encoding is visible on the present_state debug port, so the values are fixed.
package baccarat_statemachine_pkg;

    typedef enum logic [2:0] {
        ST_P1     = 3'b000,
        ST_D1     = 3'b001,
        ST_P2     = 3'b010,
        ST_D2     = 3'b011,
        ST_P3     = 3'b100,
        ST_D3     = 3'b101,
        ST_RESULT = 3'b110
    } state_e;

    // Two-card total at or above this is a natural and ends the hand.
    localparam logic [3:0] NATURAL_MIN = 4'd8;
    // A two-card total at or above this stands on two cards.
    localparam logic [3:0] STAND_MIN   = 4'd6;

    // Load-enable vector {dcard3, pcard3, dcard2, pcard2, dcard1, pcard1} for a state.
    function automatic logic [5:0] loads_for(input state_e s);
        logic [5:0] loads;
        loads = 6'b000000;
        case (s)
            ST_P1:   loads = 6'b000001;
            ST_D1:   loads = 6'b000010;
            ST_P2:   loads = 6'b000100;
            ST_D2:   loads = 6'b001000;
            ST_P3:   loads = 6'b010000;
            ST_D3:   loads = 6'b100000;
            default: loads = 6'b000000;
        endcase
        return loads;
    endfunction

    function automatic logic is_natural(input logic [3:0] pscore, input logic [3:0] dscore);
        return (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);
    endfunction

endpackage

// File: rtl/baccarat_dealer_draw_rule.sv
// Dealer third-card rule, applied after the player has taken a third card.
// Purely combinational: decides from the dealer two-card total and the player's third card.
module baccarat_dealer_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic in2to7;
    logic in4to7;
    logic in6to7;

    assign in2to7 = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
    assign in4to7 = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
    assign in6to7 = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);

    // Totals of 7 and above, including out-of-range values, always stand.
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3 != 4'd8);
            4'd4:             draw = in2to7;
            4'd5:             draw = in4to7;
            4'd6:             draw = in6to7;
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_statemachine.sv
// Card-dealing sequencer for baccarat: issues datapath load enables one card per clock
// and applies the third-card rules, then lights the winner(s) from the live scores.
module baccarat_statemachine
    import baccarat_statemachine_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [2:0] present_state
);

    state_e     state_q;
    state_e     state_d;
    logic [5:0] loads_q;
    logic       dealer_draws;

    baccarat_dealer_draw_rule u_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (dealer_draws)
    );

    // Out of D2 the scores are the two-card totals; out of P3 dscore is still the dealer's two-card total.
    always_comb begin
        state_d = ST_P1;
        case (state_q)
            ST_P1: state_d = ST_D1;
            ST_D1: state_d = ST_P2;
            ST_P2: state_d = ST_D2;
            ST_D2: begin
                if (is_natural(pscore, dscore)) begin
                    state_d = ST_RESULT;
                end else if (pscore < STAND_MIN) begin
                    state_d = ST_P3;
                end else if (dscore < STAND_MIN) begin
                    state_d = ST_D3;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            ST_P3:     state_d = dealer_draws ? ST_D3 : ST_RESULT;
            ST_D3:     state_d = ST_RESULT;
            ST_RESULT: state_d = ST_RESULT;
            default:   state_d = ST_P1;
        endcase
    end

    // Load enables are registered alongside the state so they are glitch-free into the datapath.
    always_ff @(posedge slow_clock or posedge resetb) begin
        if (resetb) begin
            state_q <= ST_P1;
            loads_q <= loads_for(ST_P1);
        end else begin
            state_q <= state_d;
            loads_q <= loads_for(state_d);
        end
    end

    assign load_pcard1 = loads_q[0];
    assign load_dcard1 = loads_q[1];
    assign load_pcard2 = loads_q[2];
    assign load_dcard2 = loads_q[3];
    assign load_pcard3 = loads_q[4];
    assign load_dcard3 = loads_q[5];

    // Ties light both; outside RESULT neither light is on.
    assign player_win_light = (state_q == ST_RESULT) && (pscore >= dscore);
    assign dealer_win_light = (state_q == ST_RESULT) && (dscore >= pscore);

    assign present_state = state_q;

endmodule

// File: tb/tb_baccarat_statemachine.sv
// Self-checking bench for baccarat_statemachine: directed rule scenarios plus random
// hands compared against a hand-level model of the baccarat drawing rules.
module tb_baccarat_statemachine;

    logic       slow_clock = 1'b0;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
    logic [2:0] present_state;

    int total = 0;
    int bad   = 0;

    logic [5:0] loads;
    assign loads = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};

    baccarat_statemachine dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .present_state    (present_state)
    );

    always #5 slow_clock = ~slow_clock;

    // Card states load exactly one card in dealing order; RESULT (6) loads nothing.
    function automatic logic [5:0] exp_loads(input int s);
        if (s >= 0 && s < 6) return 6'(1 << s);
        return 6'b000000;
    endfunction

    // Dealer's third-card table, written as the rulebook states it.
    function automatic bit model_dealer_draws(input int d, input int c);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return (c != 8);
            4:       return (c >= 2 && c <= 7);
            5:       return (c >= 4 && c <= 7);
            6:       return (c >= 6 && c <= 7);
            default: return 1'b0;
        endcase
    endfunction

    // Apply scores for one clock; called and returns at a falling edge.
    task automatic deal(input int ps, input int ds, input int c3);
        pscore = 4'(ps);
        dscore = 4'(ds);
        pcard3 = 4'(c3);
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic restart();
        resetb = 1'b1;
        #2;
        resetb = 1'b0;
    endtask

    task automatic to_d2();
        restart();
        deal($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
        deal($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
        deal($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    task automatic test_reset();
        resetb = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        @(negedge slow_clock);
        total++;
        if (present_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", present_state); end
        total++;
        if (loads !== 6'b000001) begin bad++; $display("[TB] FAIL reset_loads: got %b want 000001", loads); end
        total++;
        if ({player_win_light, dealer_win_light} !== 2'b00) begin
            bad++; $display("[TB] FAIL reset_lights: got %b want 00", {player_win_light, dealer_win_light});
        end
        resetb = 1'b0;
        #1;
        total++;
        if (present_state !== 3'd0) begin bad++; $display("[TB] FAIL after_release_state: got %0d want 0", present_state); end
        @(negedge slow_clock);
    endtask

    task automatic test_natural_tie();
        int want[4] = '{1, 2, 3, 6};
        restart();
        pscore = 4'd0;
        dscore = 4'd0;
        deal(4, 0, 0);
        total++;
        if (present_state !== 3'(want[0])) begin bad++; $display("[TB] FAIL nat_step0: got %0d want %0d", present_state, want[0]); end
        deal(4, 4, 0);
        total++;
        if (present_state !== 3'(want[1])) begin bad++; $display("[TB] FAIL nat_step1: got %0d want %0d", present_state, want[1]); end
        deal(8, 4, 0);
        total++;
        if (present_state !== 3'(want[2])) begin bad++; $display("[TB] FAIL nat_step2: got %0d want %0d", present_state, want[2]); end
        deal(8, 8, 0);
        total++;
        if (present_state !== 3'(want[3])) begin bad++; $display("[TB] FAIL nat_step3: got %0d want %0d", present_state, want[3]); end
        total++;
        if ({player_win_light, dealer_win_light} !== 2'b11) begin
            bad++; $display("[TB] FAIL nat_tie_lights: got %b want 11", {player_win_light, dealer_win_light});
        end
    endtask

    task automatic test_dealer_seven_stands();
        to_d2();
        deal(0, 7, 0);
        total++;
        if (present_state !== 3'd4) begin bad++; $display("[TB] FAIL d7_to_p3: got %0d want 4", present_state); end
        deal(1, 7, 1);
        total++;
        if (present_state !== 3'd6) begin bad++; $display("[TB] FAIL d7_to_result: got %0d want 6", present_state); end
        total++;
        if ({player_win_light, dealer_win_light} !== 2'b01) begin
            bad++; $display("[TB] FAIL d7_lights: got %b want 01", {player_win_light, dealer_win_light});
        end
    endtask

    task automatic test_dealer_six();
        int cards[2] = '{7, 8};
        for (int k = 0; k < 2; k++) begin
            to_d2();
            deal(5, 6, 0);
            total++;
            if (present_state !== 3'd4) begin bad++; $display("[TB] FAIL d6_to_p3[%0d]: got %0d want 4", k, present_state); end
            deal(2, 6, cards[k]);
            if (cards[k] == 7) begin
                total++;
                if (present_state !== 3'd5) begin bad++; $display("[TB] FAIL d6_to_d3: got %0d want 5", present_state); end
                deal(2, 6, 0);
            end
            total++;
            if (present_state !== 3'd6) begin bad++; $display("[TB] FAIL d6_result[%0d]: got %0d want 6", k, present_state); end
            total++;
            if ({player_win_light, dealer_win_light} !== 2'b01) begin
                bad++; $display("[TB] FAIL d6_lights[%0d]: got %b want 01", k, {player_win_light, dealer_win_light});
            end
        end
    endtask

    task automatic test_p3_boundaries();
        int bDs[7]   = '{5, 5, 4, 4, 3, 3, 0};
        int bC3[7]   = '{4, 3, 4, 8, 7, 8, 7};
        int bDraw[7] = '{1, 0, 1, 0, 1, 0, 1};
        for (int k = 0; k < 7; k++) begin
            to_d2();
            deal(3, bDs[k], 0);
            deal(8, bDs[k], bC3[k]);
            total++;
            if (present_state !== (bDraw[k] != 0 ? 3'd5 : 3'd6)) begin
                bad++; $display("[TB] FAIL bound_ds%0d_c%0d: got %0d want %0d", bDs[k], bC3[k], present_state, bDraw[k] != 0 ? 5 : 6);
            end
            if (bDraw[k] != 0) deal(8, 0, 0);
            pscore = 4'd8;
            dscore = 4'd0;
            #1;
            total++;
            if ({player_win_light, dealer_win_light} !== 2'b10) begin
                bad++; $display("[TB] FAIL bound_lights[%0d]: got %b want 10", k, {player_win_light, dealer_win_light});
            end
            pscore = 4'd2;
            dscore = 4'(bDs[k]);
            #1;
            total++;
            if ({player_win_light, dealer_win_light} !== {2 >= bDs[k], bDs[k] >= 2}) begin
                bad++; $display("[TB] FAIL bound_live_lights[%0d]: got %b want %b", k,
                                {player_win_light, dealer_win_light}, {2 >= bDs[k], bDs[k] >= 2});
            end
            @(negedge slow_clock);
        end
    endtask

    task automatic test_player_stands();
        to_d2();
        deal(6, 5, 0);
        total++;
        if (present_state !== 3'd5) begin bad++; $display("[TB] FAIL stand_to_d3: got %0d want 5", present_state); end
        deal(6, 8, 0);
        total++;
        if (present_state !== 3'd6) begin bad++; $display("[TB] FAIL stand_result: got %0d want 6", present_state); end
        total++;
        if ({player_win_light, dealer_win_light} !== 2'b01) begin
            bad++; $display("[TB] FAIL stand_lights: got %b want 01", {player_win_light, dealer_win_light});
        end
        to_d2();
        deal(7, 7, 0);
        total++;
        if (present_state !== 3'd6) begin bad++; $display("[TB] FAIL both_stand: got %0d want 6", present_state); end
        total++;
        if ({player_win_light, dealer_win_light} !== 2'b11) begin
            bad++; $display("[TB] FAIL both_stand_lights: got %b want 11", {player_win_light, dealer_win_light});
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            to_d2();
            if (k == 1) deal(9, 9, 0);
            total++;
            if (present_state !== (k == 0 ? 3'd3 : 3'd6)) begin
                bad++; $display("[TB] FAIL async_pre[%0d]: got %0d want %0d", k, present_state, k == 0 ? 3 : 6);
            end
            #2;
            resetb = 1'b1;
            #1;
            total++;
            if (present_state !== 3'd0 || loads !== 6'b000001) begin
                bad++; $display("[TB] FAIL async_reset[%0d]: state=%0d loads=%b want 0/000001", k, present_state, loads);
            end
            total++;
            if ({player_win_light, dealer_win_light} !== 2'b00) begin
                bad++; $display("[TB] FAIL async_lights[%0d]: got %b want 00", k, {player_win_light, dealer_win_light});
            end
            resetb = 1'b0;
            @(negedge slow_clock);
            total++;
            if (present_state !== 3'd1) begin bad++; $display("[TB] FAIL async_resume[%0d]: got %0d want 1", k, present_state); end
        end
    endtask

    // Random hands: the model plays the hand by the rules and lists the states it must visit.
    task automatic test_random_games();
        int path[$];
        int p, d, c3, pFin, dFin, r1, r2;
        bit nat, pDraw, dDraw;
        for (int g = 0; g < 200; g++) begin
            p  = $urandom_range(0, 9);
            d  = $urandom_range(0, 9);
            c3 = $urandom_range(0, 9);
            nat   = (p >= 8) || (d >= 8);
            pDraw = !nat && (p <= 5);
            pFin  = pDraw ? (p + c3) % 10 : p;
            dDraw = pDraw ? model_dealer_draws(d, c3) : (!nat && d <= 5);
            dFin  = dDraw ? (d + $urandom_range(0, 9)) % 10 : d;
            path = '{0, 1, 2, 3};
            if (pDraw) path.push_back(4);
            if (dDraw) path.push_back(5);
            path.push_back(6);
            restart();
            foreach (path[i]) begin
                total++;
                if (present_state !== 3'(path[i]) || loads !== exp_loads(path[i])) begin
                    bad++; $display("[TB] FAIL game%0d_step%0d: state=%0d loads=%b want %0d/%b",
                                    g, i, present_state, loads, path[i], exp_loads(path[i]));
                end
                if (path[i] != 6 && {player_win_light, dealer_win_light} !== 2'b00) begin
                    total++; bad++;
                    $display("[TB] FAIL game%0d_early_light: got %b want 00", g, {player_win_light, dealer_win_light});
                end
                case (path[i])
                    3:       deal(p, d, $urandom_range(0, 9));
                    4:       deal(pFin, d, c3);
                    5:       deal(pFin, dFin, c3);
                    6:       ;
                    default: deal($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
                endcase
            end
            total++;
            if ({player_win_light, dealer_win_light} !== {pFin >= dFin, dFin >= pFin}) begin
                bad++; $display("[TB] FAIL game%0d_lights: p=%0d d=%0d got %b want %b", g, pFin, dFin,
                                {player_win_light, dealer_win_light}, {pFin >= dFin, dFin >= pFin});
            end
            r1 = $urandom_range(0, 9);
            r2 = $urandom_range(0, 9);
            deal(r1, r2, $urandom_range(0, 9));
            total++;
            if (present_state !== 3'd6 || {player_win_light, dealer_win_light} !== {r1 >= r2, r2 >= r1}) begin
                bad++; $display("[TB] FAIL game%0d_hold: state=%0d lights=%b want 6/%b", g, present_state,
                                {player_win_light, dealer_win_light}, {r1 >= r2, r2 >= r1});
            end
        end
    endtask

    // Directed rule scenarios first, then the randomized hands, then one summary line.
    initial begin
        test_reset();
        test_natural_tie();
        test_dealer_seven_stands();
        test_dealer_six();
        test_p3_boundaries();
        test_player_stands();
        test_async_reset();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
